// File: rtl/lsu.sv
// rtl/lsu.sv - RV32I load/store unit driving a request/grant/response data bus.
// One access per instruction; stall holds the PC until the single-cycle done pulse.
module lsu #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_wen,
  input  logic [2:0]  req_mode,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TLIM = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          we_q, we_d;
  logic [31:0]   addr_q, addr_d;
  logic [3:0]    be_q, be_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [2:0]    mode_q, mode_d;
  logic [1:0]    off_q, off_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;

  logic          illegal;
  logic          timeout_hit;
  logic [3:0]    be_new;
  logic [31:0]   wdata_new;
  logic [31:0]   lane_word;
  logic [15:0]   half;
  logic [31:0]   load_ext;

  always_comb begin
    illegal = 1'b0;
    case (req_mode)
      3'd0:    illegal = 1'b0;
      3'd1:    illegal = req_addr[0];
      3'd2:    illegal = (req_addr[1:0] != 2'b00);
      3'd4:    illegal = req_wen;
      3'd5:    illegal = req_wen || req_addr[0];
      default: illegal = 1'b1;
    endcase
  end

  // Store data is replicated across all lanes; byte enables pick the target lane.
  always_comb begin
    be_new    = 4'b1111;
    wdata_new = 32'h0;
    if (req_wen) begin
      case (req_mode[1:0])
        2'd0: begin
          be_new    = 4'b0001 << req_addr[1:0];
          wdata_new = {4{req_wdata[7:0]}};
        end
        2'd1: begin
          be_new    = req_addr[1] ? 4'b1100 : 4'b0011;
          wdata_new = {2{req_wdata[15:0]}};
        end
        default: begin
          be_new    = 4'b1111;
          wdata_new = req_wdata;
        end
      endcase
    end
  end

  always_comb begin
    lane_word = bus_rdata >> {off_q, 3'b000};
    half      = off_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (mode_q)
      3'd0:    load_ext = {{24{lane_word[7]}}, lane_word[7:0]};
      3'd1:    load_ext = {{16{half[15]}}, half};
      3'd4:    load_ext = {24'h0, lane_word[7:0]};
      3'd5:    load_ext = {16'h0, half};
      default: load_ext = bus_rdata;
    endcase
  end

  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == TLIM);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    mode_d  = mode_q;
    off_d   = off_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (illegal) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            we_d    = req_wen;
            addr_d  = {req_addr[31:2], 2'b00};
            be_d    = be_new;
            wdata_d = wdata_new;
            mode_d  = req_mode;
            off_d   = req_addr[1:0];
            cnt_d   = '0;
            err_d   = 1'b0;
            state_d = REQ;
          end
        end
      end
      REQ: begin
        cnt_d = cnt_q + 1'b1;
        // A grant landing on the timeout cycle loses to the abort.
        if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else if (bus_gnt) begin
          state_d = we_q ? DONE : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else if (bus_rvalid) begin
          rdata_d = load_ext;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= 32'h0;
      be_q    <= 4'h0;
      wdata_q <= 32'h0;
      mode_q  <= 3'd0;
      off_q   <= 2'd0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      mode_q  <= mode_d;
      off_q   <= off_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign done      = (state_q == DONE);
  assign err       = done && err_q;
  assign stall     = !rst && req_valid && !done;
  assign rdata     = rdata_q;
  assign bus_req   = (state_q == REQ);
  assign bus_we    = we_q;
  assign bus_addr  = addr_q;
  assign bus_be    = be_q;
  assign bus_wdata = wdata_q;

endmodule

// File: tb/tb_lsu.sv
// tb/tb_lsu.sv - randomized bench for lsu against a cycle-count reference model.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_wen;
  logic [2:0]  req_mode;
  logic [31:0] req_addr, req_wdata;
  logic        bus_gnt, bus_rvalid;
  logic [31:0] bus_rdata;

  logic        a_stall, a_done, a_err, a_bus_req, a_bus_we;
  logic [31:0] a_rdata, a_bus_addr, a_bus_wdata;
  logic [3:0]  a_bus_be;
  logic        b_stall, b_done, b_err, b_bus_req, b_bus_we;
  logic [31:0] b_rdata, b_bus_addr, b_bus_wdata;
  logic [3:0]  b_bus_be;

  logic        sel = 1'b0;
  logic        o_stall, o_done, o_err, o_bus_req, o_bus_we;
  logic [31:0] o_rdata, o_bus_addr, o_bus_wdata;
  logic [3:0]  o_bus_be;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_rd  = 32'h0;

  always #5 clk = ~clk;

  lsu #(.TIMEOUT(8)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_wen(req_wen), .req_mode(req_mode),
    .req_addr(req_addr), .req_wdata(req_wdata), .stall(a_stall), .done(a_done), .err(a_err),
    .rdata(a_rdata), .bus_req(a_bus_req), .bus_we(a_bus_we), .bus_addr(a_bus_addr),
    .bus_be(a_bus_be), .bus_wdata(a_bus_wdata), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid),
    .bus_rdata(bus_rdata)
  );

  lsu #(.TIMEOUT(4)) u_dut_to4 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_wen(req_wen), .req_mode(req_mode),
    .req_addr(req_addr), .req_wdata(req_wdata), .stall(b_stall), .done(b_done), .err(b_err),
    .rdata(b_rdata), .bus_req(b_bus_req), .bus_we(b_bus_we), .bus_addr(b_bus_addr),
    .bus_be(b_bus_be), .bus_wdata(b_bus_wdata), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid),
    .bus_rdata(bus_rdata)
  );

  assign o_stall     = sel ? b_stall     : a_stall;
  assign o_done      = sel ? b_done      : a_done;
  assign o_err       = sel ? b_err       : a_err;
  assign o_rdata     = sel ? b_rdata     : a_rdata;
  assign o_bus_req   = sel ? b_bus_req   : a_bus_req;
  assign o_bus_we    = sel ? b_bus_we    : a_bus_we;
  assign o_bus_addr  = sel ? b_bus_addr  : a_bus_addr;
  assign o_bus_be    = sel ? b_bus_be    : a_bus_be;
  assign o_bus_wdata = sel ? b_bus_wdata : a_bus_wdata;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%08h exp=%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] extend(input logic [2:0] mode, input logic [1:0] off,
                                         input logic [31:0] word);
    logic [31:0] sh;
    logic [31:0] v;
    sh = word >> (8 * off);
    case (mode)
      3'd0: begin v = sh & 32'hFF;   if (v >= 32'd128)   v = v + 32'hFFFF_FF00; end
      3'd1: begin v = sh & 32'hFFFF; if (v >= 32'd32768) v = v + 32'hFFFF_0000; end
      3'd4: v = sh & 32'hFF;
      3'd5: v = sh & 32'hFFFF;
      default: v = word;
    endcase
    return v;
  endfunction

  task automatic reset_check();
    @(negedge clk);
    rst = 1'b1; req_valid = 1'b0; req_wen = 1'b0; req_mode = 3'd0; req_addr = 32'h0;
    req_wdata = 32'h0; bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'h0;
    @(negedge clk);
    chk("rst_done", 32'(o_done), 32'h0);
    chk("rst_err", 32'(o_err), 32'h0);
    chk("rst_bus_req", 32'(o_bus_req), 32'h0);
    chk("rst_bus_we", 32'(o_bus_we), 32'h0);
    chk("rst_bus_addr", o_bus_addr, 32'h0);
    chk("rst_bus_be", 32'(o_bus_be), 32'h0);
    chk("rst_bus_wdata", o_bus_wdata, 32'h0);
    chk("rst_rdata", o_rdata, 32'h0);
    rst = 1'b0;
    exp_rd = 32'h0;
  endtask

  // g: REQ cycles without grant before the granting cycle; d: WAIT cycle carrying rvalid.
  task automatic access(input logic wen, input logic [2:0] mode, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] word,
                        input int g, input int d, input bit noise);
    int          to, n, exp_done, reqlast;
    bit          legal, exp_err, seen;
    logic [31:0] exp_be, exp_wd, exp_addr;
    to = sel ? 4 : 8;
    case (mode)
      3'd0, 3'd4: legal = !(wen && mode == 3'd4);
      3'd1, 3'd5: legal = !addr[0] && !(wen && mode == 3'd5);
      3'd2:       legal = (addr[1:0] == 2'b00);
      default:    legal = 1'b0;
    endcase
    n = wen ? g + 1 : g + 1 + d;
    if (!legal) begin
      exp_done = 1; exp_err = 1'b1;
    end else if (to != 0 && n >= to) begin
      exp_done = to + 1; exp_err = 1'b1;
    end else begin
      exp_done = n + 1; exp_err = 1'b0;
    end
    reqlast  = (to != 0 && g + 1 >= to) ? to : g + 1;
    exp_addr = addr & 32'hFFFF_FFFC;
    exp_be   = 32'hF;
    exp_wd   = 32'h0;
    if (wen) begin
      case (mode[1:0])
        2'd0:    begin exp_be = 32'h1 << addr[1:0]; exp_wd = (wdata & 32'hFF) * 32'h0101_0101; end
        2'd1:    begin exp_be = addr[1] ? 32'hC : 32'h3; exp_wd = (wdata & 32'hFFFF) * 32'h0001_0001; end
        default: exp_wd = wdata;
      endcase
    end
    @(negedge clk);
    req_valid = 1'b1; req_wen = wen; req_mode = mode; req_addr = addr; req_wdata = wdata;
    bus_gnt = 1'b0; bus_rvalid = 1'b0;
    seen = 1'b0;
    for (int k = 1; k <= 40 && !seen; k++) begin
      @(negedge clk);
      chk("done", 32'(o_done), 32'(k == exp_done));
      chk("stall", 32'(o_stall), 32'(k != exp_done));
      chk("bus_req", 32'(o_bus_req), 32'(legal && k <= reqlast));
      if (legal && k <= reqlast) begin
        chk("bus_addr", o_bus_addr, exp_addr);
        chk("bus_be", 32'(o_bus_be), exp_be);
        chk("bus_wdata", o_bus_wdata, exp_wd);
        chk("bus_we", 32'(o_bus_we), 32'(wen));
      end
      if (o_done) begin
        seen = 1'b1;
        if (legal && !wen && !exp_err) exp_rd = extend(mode, addr[1:0], word);
        chk("err", 32'(o_err), 32'(exp_err));
        chk("rdata", o_rdata, exp_rd);
      end else begin
        bus_gnt = (k == g + 1);
        if (wen) begin
          bus_rvalid = noise && ($urandom_range(1) == 1);
          bus_rdata  = $urandom;
        end else begin
          bus_rvalid = (k == g + 1 + d);
          bus_rdata  = (k == g + 1 + d) ? word : $urandom;
        end
      end
    end
    chk("done_seen", 32'(seen), 32'h1);
    req_valid = 1'b0; bus_gnt = 1'b0; bus_rvalid = 1'b0;
  endtask

  initial begin
    reset_check();

    access(1'b0, 3'd0, 32'h103, 32'h0, 32'h80FF_1234, 0, 1, 1'b0);
    chk("lb_rdata", o_rdata, 32'hFFFF_FF80);
    access(1'b0, 3'd5, 32'h202, 32'h0, 32'h8001_0000, 0, 1, 1'b0);
    chk("lhu_rdata", o_rdata, 32'h0000_8001);
    access(1'b0, 3'd1, 32'h202, 32'h0, 32'h8001_0000, 0, 1, 1'b0);
    chk("lh_rdata", o_rdata, 32'hFFFF_8001);
    access(1'b1, 3'd0, 32'h41, 32'hDEAD_BEA5, 32'h0, 3, 1, 1'b1);
    access(1'b0, 3'd2, 32'h06, 32'h0, 32'h1234_5678, 0, 1, 1'b0);
    chk("misaligned_keeps_rdata", o_rdata, 32'hFFFF_8001);
    access(1'b1, 3'd5, 32'h20, 32'h5555_AAAA, 32'h0, 0, 1, 1'b0);
    access(1'b0, 3'd2, 32'h400, 32'h0, 32'hCAFE_F00D, 2, 3, 1'b0);

    for (int i = 0; i < 200; i++) begin
      access(1'($urandom_range(1)), 3'($urandom_range(7)), $urandom, $urandom, $urandom,
             int'($urandom_range(5)), int'($urandom_range(4, 1)), 1'b1);
    end

    reset_check();
    sel = 1'b1;
    access(1'b0, 3'd2, 32'h100, 32'h0, 32'h0, 100, 1, 1'b0);
    sel = 1'b0;

    reset_check();
    access(1'b0, 3'd0, 32'h13, 32'h0, 32'h0000_7F00, 0, 1, 1'b0);
    @(negedge clk);
    req_valid = 1'b1; req_wen = 1'b0; req_mode = 3'd2; req_addr = 32'h10; req_wdata = 32'h0;
    @(negedge clk);
    bus_gnt = 1'b1;
    @(negedge clk);
    bus_gnt = 1'b0;
    chk("wait_stall", 32'(o_stall), 32'h1);
    rst = 1'b1;
    #1;
    chk("rst_stall", 32'(o_stall), 32'h0);
    @(negedge clk);
    rst = 1'b0; req_valid = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'h1357_9BDF;
    chk("mid_done", 32'(o_done), 32'h0);
    chk("mid_bus_req", 32'(o_bus_req), 32'h0);
    chk("mid_bus_addr", o_bus_addr, 32'h0);
    chk("mid_bus_be", 32'(o_bus_be), 32'h0);
    chk("mid_rdata", o_rdata, 32'h0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      bus_rvalid = 1'b0;
      chk("post_rst_done", 32'(o_done), 32'h0);
      chk("post_rst_rdata", o_rdata, 32'h0);
      chk("post_rst_bus_req", 32'(o_bus_req), 32'h0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
